// File: rtl/or1_cells_pkg.sv
// Shared constants and helpers for the or1 sequential cell library.
package or1_cells_pkg;

  // Capture edge selectors for the NEG_EDGE parameter of library cells.
  localparam bit EDGE_NEG = 1'b1;
  localparam bit EDGE_POS = 1'b0;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffr_pipe_stage.sv
// One elastic register stage: valid bit plus data word, with async reset,
// synchronous flush and a local readiness term for the upstream chain.
module dffr_pipe_stage
  import or1_cells_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter bit               NEG_EDGE  = EDGE_NEG,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             VIN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RIN,
  output logic             VOUT,
  output logic [WIDTH-1:0] DOUT,
  output logic             ROUT
);

  logic             cap_clk;
  logic             v;
  logic [WIDTH-1:0] d;

  // XOR with a constant folds to either a wire or one inverter, so both edge
  // modes share the same register logic.
  assign cap_clk = CLK ^ NEG_EDGE;

  // Stage can take a new word when it is empty or its contents move on.
  assign ROUT = ~v | RIN;

  // Stage state: flush kills the valid but keeps data; data only loads with a
  // valid word so bubbles do not toggle the data register.
  always_ff @(posedge cap_clk or posedge RST) begin
    if (RST) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (FLUSH) begin
      v <= 1'b0;
    end else if (ROUT) begin
      v <= VIN;
      if (VIN) begin
        d <= DIN;
      end
    end
  end

  assign VOUT = v;
  assign DOUT = d;

endmodule

// File: rtl/dffr_pipe.sv
// Parametrised elastic register pipeline with valid/ready flow control,
// flush and occupancy count; DEPTH stages of dffr_pipe_stage.
module dffr_pipe
  import or1_cells_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter bit               NEG_EDGE  = EDGE_NEG,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [WIDTH-1:0]             D,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [WIDTH-1:0]             Q,
  output logic [occ_width(DEPTH)-1:0]  OCC
);

  localparam int unsigned OW = occ_width(DEPTH);

  logic [DEPTH-1:0] v;

  // Each stage keeps its link signals local to its generate scope so the
  // ready chain is a series of distinct nets rather than one self-dependent
  // vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic             rin;
    logic             vout;
    logic             rout;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    if (i == 0) begin : g_head
      assign vin = IN_VALID;
      assign din = D;
    end else begin : g_link
      assign vin = g_stage[i-1].vout;
      assign din = g_stage[i-1].dout;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign rin = OUT_READY;
    end else begin : g_fwd
      assign rin = g_stage[i+1].rout;
    end

    dffr_pipe_stage #(
      .WIDTH     (WIDTH),
      .NEG_EDGE  (NEG_EDGE),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .CLK   (CLK),
      .RST   (RST),
      .FLUSH (FLUSH),
      .VIN   (vin),
      .DIN   (din),
      .RIN   (rin),
      .VOUT  (vout),
      .DOUT  (dout),
      .ROUT  (rout)
    );

    assign v[i] = vout;
  end

  assign IN_READY  = g_stage[0].rout & ~FLUSH;
  assign OUT_VALID = v[DEPTH-1] & ~FLUSH;
  assign Q         = g_stage[DEPTH-1].dout;

  // Occupancy: popcount of the stage valid registers, so it changes only on
  // the same active edge (or reset) that changes the valids.
  always_comb begin
    OCC = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      OCC = OCC + OW'(v[i]);
    end
  end

endmodule
